mil_bc_sequencer: RTL

Bus-controller message sequencer for the MIL-STD-1553B core. It runs one complete message per start request: command word, data words, then the RT status word. It drives the word-level transmitter (EN/CD/DATA/BUSY) and consumes the word-level receiver (DONE/CD/DATA/PARITY_ERROR). Transmit data comes from an external 32x16 buffer; received data goes to a second 32x16 buffer. It sits beside the existing control block on the 25 MHz word-clock domain.

---
 rtl/mil_bc_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mil_bc_sequencer.sv
// rtl/mil_bc_sequencer.sv - MIL-STD-1553B bus-controller message sequencer
// Runs one command/data/status message per start on the word-clock domain.
module mil_bc_sequencer #(
  parameter int TIMEOUT = 350,
  parameter int TO_W    = 9
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic        iSTART,
  input  logic [15:0] iCMD,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [15:0] oSTATUS,
  output logic [3:0]  oERR,
  output logic        oTX_EN,
  output logic        oTX_CD,
  output logic [15:0] oTX_DATA,
  input  logic        iTX_BUSY,
  output logic [4:0]  oTXBUF_A,
  input  logic [15:0] iTXBUF_D,
  input  logic        iRX_DONE,
  input  logic        iRX_CD,
  input  logic [15:0] iRX_DATA,
  input  logic        iRX_PERR,
  output logic        oRXBUF_WE,
  output logic [4:0]  oRXBUF_A,
  output logic [15:0] oRXBUF_D
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_CMD, S_TX_DATA, S_WAIT_STATUS, S_RX_DATA, S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      tx_ph;
  logic [15:0]     cmd;
  logic [5:0]      wcnt;
  logic [TO_W-1:0] tcnt;
  logic [4:0]      rx_ptr;

  logic [5:0] n_words;
  logic       last_word;
  logic       bcast;
  logic       timed_out;

  assign n_words   = (cmd[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd[4:0]};
  assign last_word = (wcnt == n_words - 6'd1);
  assign bcast     = (cmd[15:11] == 5'd31);
  assign timed_out = (tcnt >= TO_W'(TIMEOUT));

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state     <= S_IDLE;
      tx_ph     <= 2'd0;
      cmd       <= 16'd0;
      wcnt      <= 6'd0;
      tcnt      <= '0;
      rx_ptr    <= 5'd0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oSTATUS   <= 16'd0;
      oERR      <= 4'd0;
      oTX_EN    <= 1'b0;
      oTX_CD    <= 1'b0;
      oTX_DATA  <= 16'd0;
      oTXBUF_A  <= 5'd0;
      oRXBUF_WE <= 1'b0;
      oRXBUF_A  <= 5'd0;
      oRXBUF_D  <= 16'd0;
    end else begin
      oDONE     <= 1'b0;
      oTX_EN    <= 1'b0;
      oRXBUF_WE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iSTART) begin
            cmd      <= iCMD;
            oTXBUF_A <= 5'd0;
            tx_ph    <= 2'd0;
            wcnt     <= 6'd0;
            // A broadcast transmit request has no legal responder: abort untransmitted.
            if (iCMD[15:11] == 5'd31 && iCMD[10]) begin
              oERR  <= 4'b1000;
              state <= S_DONE;
              oDONE <= 1'b1;
            end else begin
              oERR  <= 4'd0;
              oBUSY <= 1'b1;
              state <= S_TX_CMD;
            end
          end
        end

        S_TX_CMD, S_TX_DATA: begin
          case (tx_ph)
            2'd0: begin
              if (!iTX_BUSY) begin
                oTX_EN   <= 1'b1;
                oTX_CD   <= (state == S_TX_CMD);
                oTX_DATA <= (state == S_TX_CMD) ? cmd : iTXBUF_D;
                if (state == S_TX_DATA) oTXBUF_A <= oTXBUF_A + 5'd1;
                tx_ph <= 2'd1;
              end
            end
            2'd1: if (iTX_BUSY) tx_ph <= 2'd2;
            default: begin
              if (!iTX_BUSY) begin
                tx_ph <= 2'd0;
                tcnt  <= '0;
                if (state == S_TX_CMD) begin
                  state <= cmd[10] ? S_WAIT_STATUS : S_TX_DATA;
                end else begin
                  wcnt <= wcnt + 6'd1;
                  if (last_word) begin
                    if (bcast) begin state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0; end
                    else state <= S_WAIT_STATUS;
                  end
                end
              end
            end
          endcase
        end

        S_WAIT_STATUS: begin
          if (iRX_DONE) begin
            if (iRX_PERR) begin
              oERR[1] <= 1'b1;
              state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
            end else if (iRX_CD) begin
              oSTATUS <= iRX_DATA;
              if (iRX_DATA[15:11] != cmd[15:11]) begin
                oERR[2] <= 1'b1;
                state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
              end else if (cmd[10]) begin
                state  <= S_RX_DATA;
                tcnt   <= '0;
                wcnt   <= 6'd0;
                rx_ptr <= 5'd0;
              end else begin
                state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end else if (timed_out) begin
            oERR[0] <= 1'b1;
            state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end

        S_RX_DATA: begin
          if (iRX_DONE) begin
            if (iRX_PERR) begin
              oERR[1] <= 1'b1;
              state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
            end else if (iRX_CD) begin
              oERR[0] <= 1'b1;
              state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
            end else begin
              oRXBUF_WE <= 1'b1;
              oRXBUF_A  <= rx_ptr;
              oRXBUF_D  <= iRX_DATA;
              rx_ptr    <= rx_ptr + 5'd1;
              wcnt      <= wcnt + 6'd1;
              tcnt      <= '0;
              if (last_word) begin state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0; end
            end
          end else if (timed_out) begin
            oERR[0] <= 1'b1;
            state <= S_DONE; oDONE <= 1'b1; oBUSY <= 1'b0;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
